// File: rtl/despread_pkg.sv
// Shared constants and types for the despread / unpack receive path.
package despread_pkg;

    // Spreading code shared with the transmit spreader; chip 0 uses the MSB.
    localparam logic [23:0] PN_CODE_DEFAULT = 24'hE25A3C;

    // Accumulator width: chip width, growth over SPREAD terms, plus sign headroom.
    function automatic int unsigned acc_width(input int unsigned chip_w, input int unsigned spread);
        return chip_w + $clog2(spread) + 1;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/despread_corr.sv
// Per-bit PN correlator: tracks chip index, accumulates PN-signed chips and
// produces a combinational hard decision plus confidence flag on the last chip.
module despread_corr
    import despread_pkg::*;
#(
    parameter int unsigned       CHIP_W  = 16,
    parameter int unsigned       SPREAD  = 24,
    parameter logic [SPREAD-1:0] PN_CODE = PN_CODE_DEFAULT,
    parameter int unsigned       THRESH  = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [CHIP_W-1:0] i_data,
    input  logic              i_chip,
    input  logic              i_restart,
    output logic              o_bit_done_c,
    output logic              o_bit_c,
    output logic              o_low_c
);

    localparam int unsigned      ACC_W = acc_width(CHIP_W, SPREAD);
    localparam int unsigned      CNT_W = (SPREAD > 1) ? $clog2(SPREAD) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SPREAD - 1);
    localparam logic [ACC_W-1:0] THR   = ACC_W'(THRESH);

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_chip_cnt;

    logic [CNT_W-1:0]        w_idx;
    logic                    w_pn;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0]        w_mag;

    // Chip term, running sum and decision; a restart chip is treated as chip 0.
    always_comb begin
        w_idx = i_restart ? '0 : r_chip_cnt;
        w_pn  = 1'b0;
        for (int k = 0; k < SPREAD; k++) begin
            if (w_idx == CNT_W'(k)) begin
                w_pn = PN_CODE[SPREAD-1-k];
            end
        end
        w_ext        = {{(ACC_W-CHIP_W){i_data[CHIP_W-1]}}, i_data};
        w_term       = w_pn ? -w_ext : w_ext;
        w_base       = i_restart ? '0 : r_acc;
        w_sum        = w_base + w_term;
        w_mag        = w_sum[ACC_W-1] ? -w_sum : w_sum;
        o_bit_done_c = i_chip && (w_idx == LAST);
        o_bit_c      = w_sum[ACC_W-1];
        o_low_c      = (w_mag <= THR);
    end

    // Accumulator and chip counter; both clear at the end of every bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc      <= '0;
            r_chip_cnt <= '0;
        end else if (i_chip) begin
            if (w_idx == LAST) begin
                r_acc      <= '0;
                r_chip_cnt <= '0;
            end else begin
                r_acc      <= w_sum;
                r_chip_cnt <= w_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/despread_unpack.sv
// Despreader and bit unpacker: syncs on i_sync, correlates chips into bits and
// assembles MSB-first words behind a valid/ready output register.
module despread_unpack
    import despread_pkg::*;
#(
    parameter int unsigned       CHIP_W          = 16,
    parameter int unsigned       SPREAD          = 24,
    parameter logic [SPREAD-1:0] PN_CODE         = PN_CODE_DEFAULT,
    parameter int unsigned       SIZE_OUTPUT_BIT = 8,
    parameter int unsigned       THRESH          = 0
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [CHIP_W-1:0]          i_data,
    input  logic                       i_valid,
    input  logic                       i_sync,
    output logic [SIZE_OUTPUT_BIT-1:0] o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_lock,
    output logic                       o_low_conf,
    output logic                       o_overflow
);

    localparam int unsigned       BCNT_W   = $clog2(SIZE_OUTPUT_BIT + 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(SIZE_OUTPUT_BIT - 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [BCNT_W-1:0]          r_bit_cnt;
    logic [SIZE_OUTPUT_BIT-1:0] r_shift;
    logic                       r_pending;
    logic [SIZE_OUTPUT_BIT-1:0] r_data;
    logic                       r_valid;
    logic                       r_lock;
    logic                       r_low_conf;
    logic                       r_overflow;

    logic                       w_chip;
    logic                       w_restart;
    logic                       w_bit_done;
    logic                       w_bit;
    logic                       w_bit_low;
    logic [BCNT_W-1:0]          w_bit_idx;
    logic [SIZE_OUTPUT_BIT-1:0] w_shift_base;
    logic                       w_pending_base;
    logic [SIZE_OUTPUT_BIT-1:0] w_word;
    logic                       w_word_done;
    logic                       w_can_load;

    despread_corr #(
        .CHIP_W  (CHIP_W),
        .SPREAD  (SPREAD),
        .PN_CODE (PN_CODE),
        .THRESH  (THRESH)
    ) u_corr (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_data       (i_data),
        .i_chip       (w_chip),
        .i_restart    (w_restart),
        .o_bit_done_c (w_bit_done),
        .o_bit_c      (w_bit),
        .o_low_c      (w_bit_low)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave IDLE on the first sync chip; only reset returns to IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_valid && i_sync) w_state_next = TRACK;
            TRACK:   w_state_next = TRACK;
            default: w_state_next = IDLE;
        endcase
    end

    // Chip qualification and word assembly; a sync chip discards the partial word.
    always_comb begin
        w_restart      = i_valid && i_sync;
        w_chip         = i_valid && ((r_state == TRACK) || i_sync);
        w_bit_idx      = w_restart ? '0 : r_bit_cnt;
        w_shift_base   = w_restart ? '0 : r_shift;
        w_pending_base = w_restart ? 1'b0 : r_pending;
        w_word         = {w_shift_base[SIZE_OUTPUT_BIT-2:0], w_bit};
        w_word_done    = w_bit_done && (w_bit_idx == LAST_BIT);
        w_can_load     = !r_valid || i_ready;
    end

    // Unpack shift register, bit counter and pending low-confidence flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_pending <= 1'b0;
        end else if (w_bit_done) begin
            if (w_word_done) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
                r_pending <= 1'b0;
            end else begin
                r_bit_cnt <= w_bit_idx + 1'b1;
                r_shift   <= w_word;
                r_pending <= w_pending_base | w_bit_low;
            end
        end else if (w_restart) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_pending <= 1'b0;
        end
    end

    // Output register: load on completion if free or draining, else flag overflow.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_lock     <= 1'b0;
            r_low_conf <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_lock <= (w_state_next == TRACK);
            if (w_word_done) begin
                if (w_can_load) begin
                    r_data     <= w_word;
                    r_valid    <= 1'b1;
                    r_low_conf <= w_pending_base | w_bit_low;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data     = r_data;
    assign o_valid    = r_valid;
    assign o_lock     = r_lock;
    assign o_low_conf = r_low_conf;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_despread_unpack.sv
// Scoreboard bench for despread_unpack: spreads known bytes with the PN code
// and checks recovered words, flags and handshake behaviour.
`timescale 1ns/1ps
module tb_despread_unpack;

    localparam int unsigned CHIP_W = 16;
    localparam int unsigned SPREAD = 24;
    localparam int unsigned NBIT   = 8;
    localparam int          NCHIPS = 192;

    typedef struct {
        logic [7:0] data;
        logic       low;
    } exp_t;

    logic              i_clk   = 1'b0;
    logic              i_reset = 1'b0;
    logic [CHIP_W-1:0] i_data  = '0;
    logic              i_valid = 1'b0;
    logic              i_sync  = 1'b0;
    logic              i_ready = 1'b0;
    logic [NBIT-1:0]   o_data;
    logic              o_valid, o_lock, o_low_conf, o_overflow;
    logic [NBIT-1:0]   t_data;
    logic              t_valid, t_lock, t_low_conf, t_overflow;

    logic [23:0] pn_code = 24'hE25A3C;
    exp_t        sb[$];
    bit          sb_en   = 1'b0;
    int          n_vec   = 0;
    int          n_fail  = 0;

    despread_unpack #(.THRESH(0)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .i_sync(i_sync), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_lock(o_lock), .o_low_conf(o_low_conf), .o_overflow(o_overflow)
    );

    despread_unpack #(.THRESH(20)) dut_t (
        .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid),
        .i_sync(i_sync), .o_data(t_data), .o_valid(t_valid), .i_ready(i_ready),
        .o_lock(t_lock), .o_low_conf(t_low_conf), .o_overflow(t_overflow)
    );

    always #5 i_clk = ~i_clk;

    // One clock; pops the scoreboard whenever a word is handed off.
    task automatic tick();
        exp_t e;
        @(posedge i_clk);
        #1;
        if (sb_en && o_valid && i_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word got=%h expected=none", o_data);
            end else begin
                e = sb.pop_front();
                if (o_data !== e.data || o_low_conf !== e.low) begin
                    n_fail++;
                    $display("FAIL word got=%h/low=%b expected=%h/low=%b", o_data, o_low_conf, e.data, e.low);
                end
            end
        end
    endtask

    // Spread byte b MSB-first; ninv chips per bit are inverted to degrade correlation.
    task automatic send_byte(input logic [7:0] b, input bit sync, input int amp, input int ninv,
                             input int nchips, input bit gaps, input bit push);
        exp_t e;
        int   bi, c, v, mag;
        logic bitv, tx;
        if (push && nchips == NCHIPS) begin
            mag    = amp * (SPREAD - 2 * ninv);
            if (mag < 0) mag = -mag;
            e.data = b;
            e.low  = (mag <= 0);
            sb.push_back(e);
        end
        for (int k = 0; k < nchips; k++) begin
            bi   = k / SPREAD;
            c    = k % SPREAD;
            bitv = b[7-bi];
            tx   = bitv ^ pn_code[23-c];
            v    = tx ? -amp : amp;
            if (c < ninv) v = -v;
            if (gaps) begin
                i_valid = 1'b0;
                i_sync  = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            i_data  = 16'(v);
            i_valid = 1'b1;
            i_sync  = sync && (k == 0);
            tick();
        end
        i_valid = 1'b0;
        i_sync  = 1'b0;
    endtask

    task automatic apply_reset();
        i_valid = 1'b0;
        i_sync  = 1'b0;
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        #1 i_reset = 1'b1;
        #1;
        n_vec += 5;
        if (o_data !== 8'h00)   begin n_fail++; $display("FAIL reset_data got=%h expected=00", o_data); end
        if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid got=%b expected=0", o_valid); end
        if (o_lock !== 1'b0)    begin n_fail++; $display("FAIL reset_lock got=%b expected=0", o_lock); end
        if (o_low_conf !== 1'b0) begin n_fail++; $display("FAIL reset_low got=%b expected=0", o_low_conf); end
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b expected=0", o_overflow); end
        apply_reset();
    endtask

    task automatic test_basic();
        apply_reset();
        i_ready = 1'b1;
        sb_en   = 1'b1;
        send_byte(8'hA5, 1'b1, 1000, 0, NCHIPS, 1'b0, 1'b1);
        n_vec += 5;
        if (o_valid !== 1'b1)    begin n_fail++; $display("FAIL basic_latency got=%b expected=1", o_valid); end
        if (o_data !== 8'hA5)    begin n_fail++; $display("FAIL basic_data got=%h expected=a5", o_data); end
        if (o_low_conf !== 1'b0) begin n_fail++; $display("FAIL basic_low got=%b expected=0", o_low_conf); end
        if (o_lock !== 1'b1)     begin n_fail++; $display("FAIL basic_lock got=%b expected=1", o_lock); end
        tick();
        if (o_valid !== 1'b0)    begin n_fail++; $display("FAIL basic_pulse got=%b expected=0", o_valid); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        i_ready = 1'b1;
        sb_en   = 1'b1;
        send_byte(8'h00, 1'b1, 1000, 0, NCHIPS, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b0, 1000, 0, NCHIPS, 1'b1, 1'b1);
        send_byte(8'h3C, 1'b0, 1000, 0, NCHIPS, 1'b1, 1'b1);
        repeat (4) tick();
        n_vec += 2;
        if (sb.size() != 0)      begin n_fail++; $display("FAIL b2b_missing got=%0d expected=0", sb.size()); end
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got=%b expected=0", o_overflow); end
    endtask

    task automatic test_overflow();
        apply_reset();
        i_ready = 1'b0;
        sb_en   = 1'b0;
        send_byte(8'h12, 1'b1, 1000, 0, NCHIPS, 1'b0, 1'b0);
        n_vec += 3;
        if (o_valid !== 1'b1)    begin n_fail++; $display("FAIL ovf_first_valid got=%b expected=1", o_valid); end
        if (o_data !== 8'h12)    begin n_fail++; $display("FAIL ovf_first_data got=%h expected=12", o_data); end
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b expected=0", o_overflow); end
        send_byte(8'h34, 1'b0, 1000, 0, NCHIPS, 1'b0, 1'b0);
        n_vec += 3;
        if (o_valid !== 1'b1)    begin n_fail++; $display("FAIL ovf_hold_valid got=%b expected=1", o_valid); end
        if (o_data !== 8'h12)    begin n_fail++; $display("FAIL ovf_hold_data got=%h expected=12", o_data); end
        if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b expected=1", o_overflow); end
        i_ready = 1'b1;
        tick();
        n_vec += 2;
        if (o_valid !== 1'b0)    begin n_fail++; $display("FAIL ovf_drain got=%b expected=0", o_valid); end
        if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b expected=1", o_overflow); end
    endtask

    task automatic test_sync_restart();
        apply_reset();
        i_ready = 1'b1;
        sb_en   = 1'b1;
        send_byte(8'hFF, 1'b1, 1000, 0, 50, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b1, 1000, 0, NCHIPS, 1'b0, 1'b1);
        repeat (30) tick();
        n_vec += 2;
        if (sb.size() != 0)      begin n_fail++; $display("FAIL resync_missing got=%0d expected=0", sb.size()); end
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL resync_ovf got=%b expected=0", o_overflow); end
    endtask

    task automatic test_low_conf();
        apply_reset();
        i_ready = 1'b1;
        sb_en   = 1'b1;
        send_byte(8'h96, 1'b1, 1, 3, NCHIPS, 1'b0, 1'b1);
        n_vec += 3;
        if (t_valid !== 1'b1)    begin n_fail++; $display("FAIL lowc_valid got=%b expected=1", t_valid); end
        if (t_data !== 8'h96)    begin n_fail++; $display("FAIL lowc_data got=%h expected=96", t_data); end
        if (t_low_conf !== 1'b1) begin n_fail++; $display("FAIL lowc_flag got=%b expected=1", t_low_conf); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        i_ready = 1'b0;
        sb_en   = 1'b0;
        send_byte(8'hC3, 1'b1, 1000, 0, NCHIPS, 1'b0, 1'b0);
        send_byte(8'h81, 1'b0, 1000, 0, NCHIPS, 1'b0, 1'b0);
        send_byte(8'h7E, 1'b0, 1000, 0, 100, 1'b0, 1'b0);
        n_vec += 1;
        if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_ovf got=%b expected=1", o_overflow); end
        #2 i_reset = 1'b1;
        #1;
        n_vec += 5;
        if (o_data !== 8'h00)    begin n_fail++; $display("FAIL rmid_data got=%h expected=00", o_data); end
        if (o_valid !== 1'b0)    begin n_fail++; $display("FAIL rmid_valid got=%b expected=0", o_valid); end
        if (o_lock !== 1'b0)     begin n_fail++; $display("FAIL rmid_lock got=%b expected=0", o_lock); end
        if (o_low_conf !== 1'b0) begin n_fail++; $display("FAIL rmid_low got=%b expected=0", o_low_conf); end
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf got=%b expected=0", o_overflow); end
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        i_ready = 1'b1;
        sb_en   = 1'b1;
        sb.delete();
        send_byte(8'hA5, 1'b0, 1000, 0, NCHIPS, 1'b0, 1'b0);
        repeat (4) tick();
        n_vec += 2;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b expected=0", o_valid); end
        if (o_lock !== 1'b0)  begin n_fail++; $display("FAIL idle_lock got=%b expected=0", o_lock); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_sync_restart();
        test_low_conf();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/despread_unpack.md
Name: despread_unpack

Overview:
- Receive-side counterpart of the pack -> spread transmit chain.
- Takes a stream of soft chip samples, correlates each group of SPREAD chips against the same PN code used by the transmit spreader, and hard-decides one bit per group.
- Reassembles the bits MSB-first into SIZE_OUTPUT_BIT-wide words with a valid/ready output handshake.
- Sits after the QPSK demapper / chip-timing stage, on a single clock.

Parameters:
- CHIP_W, 16, width of the signed soft chip sample.
- SPREAD, 24, chips per bit; must equal the transmit spread factor.
- PN_CODE, 24'hE25A3C, spreading code, SPREAD bits; chip 0 uses PN_CODE[SPREAD-1].
- SIZE_OUTPUT_BIT, 8, bits per output word; must equal the transmit packer input width.
- THRESH, 0, minimum |correlation| for a confident bit; unsigned, ACC_W-1 bits.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- i_data  in  CHIP_W  signed soft chip; positive = chip 0, negative = chip 1.
- i_valid  in  1  chip qualifier; the stream has no backpressure.
- i_sync  in  1  with i_valid, marks chip 0 of bit 0 of a word.
- o_data  out  SIZE_OUTPUT_BIT  recovered word, first-received bit in MSB.
- o_valid  out  1  word available.
- i_ready  in  1  downstream accepts the word.
- o_lock  out  1  high in TRACK state.
- o_low_conf  out  1  sticky; some bit of the current word had |acc| <= THRESH.
- o_overflow  out  1  sticky error; a word completed while the output was still full.

Behaviour:
- Reset (async, active-high):
  - Outputs: o_data=0, o_valid=0, o_lock=0, o_low_conf=0, o_overflow=0.
  - Internal: counters=0, accumulator=0, state=IDLE.
- ACC_W = CHIP_W + $clog2(SPREAD) + 1. Accumulator is signed; no saturation is needed at this width.
- Chip term: -i_data when the PN chip is 1, else +i_data. Sign-extend before negation; the most negative input is not special-cased.
- States:
  - IDLE: ignore chips until i_valid && i_sync. That chip is taken as chip 0 of bit 0; go to TRACK.
  - TRACK:
    - Each i_valid chip adds its term to acc and increments chip_cnt (0..SPREAD-1).
    - On chip SPREAD-1: sum = acc + term; bit = sum[MSB] (negative -> 1). Shift the bit into the shift register LSB, increment bit_cnt, and clear acc. If |sum| <= THRESH, set low_conf_pending.
- i_sync in TRACK:
  - Discards the partial bit and partial word: acc, chip_cnt and bit_cnt restart, and the current chip counts as chip 0.
  - A word already held in the output register is unaffected.
- Word completion (bit_cnt reaches SIZE_OUTPUT_BIT):
  - If o_valid=0, or (o_valid && i_ready) in that same cycle: load o_data and assert o_valid on the next edge. Latency is 1 cycle after the final chip. o_low_conf takes low_conf_pending OR'd with the current bit's flag, and pending is then cleared.
  - Else: drop the word, set o_overflow, and leave o_data unchanged.
- Output handshake:
  - o_valid && i_ready clears o_valid next cycle unless a new word loads in the same cycle; then o_valid stays 1.
  - o_data is stable while o_valid && !i_ready.
- Clearing: o_overflow clears only on reset. o_low_conf is per-word and updates with each word load.
- i_valid=0: no state change; gaps between chips of any length are allowed.
- No i_valid during IDLE ever produces output; o_lock=0 there.

Decomposition:
- Package despread_pkg holds:
  - the PN_CODE default, shared with the transmit spreader so both ends use one constant;
  - the ACC_W function;
  - the state enum {IDLE, TRACK}.
- One natural sub-module: despread_corr (PN index, accumulator, bit decision, confidence flag).
- The top level holds the FSM, unpack shift register and output register.

Test Plan:
- Byte 0xA5, 192 chips at ±1000 with PN applied, i_sync on chip 0, i_ready=1 -> o_data=0xA5, o_valid for 1 cycle, 1 cycle after chip 191; o_low_conf=0.
- Bytes 0x00, 0xFF, 0x3C back-to-back, random i_valid gaps -> words in order, o_overflow=0.
- Two words with i_ready=0 throughout -> first word held stable; second dropped; o_overflow=1.
- i_sync reasserted at chip 50 of a word, then byte 0x5A from that chip -> only 0x5A is output; no partial word appears.
- Chips at amplitude ±1 plus 3 chips inverted per bit, THRESH=20 -> correct bits; o_low_conf=1 since |acc|=18.
- Reset asserted mid-word -> all outputs 0 immediately, o_lock=0; chips without i_sync produce no output.
